// File: rtl/dc_rd_data_align_pkg.sv
// Shared types and constants for the load-side data aligner.
// Holds line/result widths, size and state encodings, and size helpers.
package dc_rd_data_align_pkg;

  localparam int C_LINE_W     = 128;
  localparam int C_DATA_W     = 64;
  localparam int C_LINE_BYTES = C_LINE_W / 8;

  typedef enum logic [1:0] {
    SZ_1B = 2'b00,
    SZ_2B = 2'b01,
    SZ_4B = 2'b10,
    SZ_8B = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC1 = 2'b01,
    ST_ACC2 = 2'b10,
    ST_OUT  = 2'b11
  } state_t;

  function automatic logic [4:0] size_nbytes(input size_t sz);
    return 5'd1 << sz;
  endfunction

  function automatic logic [C_DATA_W-1:0] size_mask(input size_t sz);
    logic [C_DATA_W-1:0] m;
    case (sz)
      SZ_1B:   m = 64'h0000_0000_0000_00FF;
      SZ_2B:   m = 64'h0000_0000_0000_FFFF;
      SZ_4B:   m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dc_rd_data_align_byte_rotate_right.sv
// Byte-granular right rotation: output byte i takes input byte (i + amt) mod NUM_BYTES.
// NUM_BYTES must be a power of two so the index wraps naturally.
module byte_rotate_right #(
  parameter int NUM_BYTES = 16
) (
  input  logic [NUM_BYTES*8-1:0]       din,
  input  logic [$clog2(NUM_BYTES)-1:0] amt,
  output logic [NUM_BYTES*8-1:0]       dout
);

  localparam int AW = $clog2(NUM_BYTES);

  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
    logic [AW-1:0] src;
    assign src              = AW'(gi) + amt;
    assign dout[gi*8 +: 8]  = din[int'(src)*8 +: 8];
  end

endmodule

// File: rtl/dc_rd_data_align.sv
// Load data aligner: extracts a 1/2/4/8-byte value from one or two cache lines,
// right-justified and zero-extended; line-crossing loads merge two accesses.
module dc_rd_data_align
  import dc_rd_data_align_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_req,
  output logic                ld_ready,
  input  logic [1:0]          mem_rd_size,
  input  logic [3:0]          addr_offset,
  input  logic                dc_rd_valid,
  input  logic [C_LINE_W-1:0] dc_rd_line,
  output logic                access2,
  input  logic                flush,
  output logic [C_DATA_W-1:0] ld_data,
  output logic                ld_data_valid
);

  state_t              state, state_next;
  size_t               size_reg;
  logic [3:0]          offset_reg;
  logic                split_reg;
  logic [C_LINE_W-1:0] hold_reg, hold_next;
  logic [C_DATA_W-1:0] ld_data_reg, ld_data_next;

  logic                accept;
  logic                split_in;
  logic [C_LINE_W-1:0] line1_rot;
  logic [C_LINE_W-1:0] line2_shl;
  logic [C_LINE_W-1:0] merged;
  logic [4:0]          first_bytes;

  assign accept   = (state == ST_IDLE) && ld_req && !flush;
  assign split_in = (5'({1'b0, addr_offset}) + size_nbytes(size_t'(mem_rd_size))) > 5'd16;

  byte_rotate_right #(.NUM_BYTES(C_LINE_BYTES)) u_rot1 (
    .din  (dc_rd_line),
    .amt  (offset_reg),
    .dout (line1_rot)
  );

  // Number of first-line bytes in the merged result; also the left-rotate amount
  // for the second line. Only used when split, so it is always 1..15.
  assign first_bytes = 5'd16 - {1'b0, offset_reg};

  for (genvar gi = 0; gi < C_LINE_BYTES; gi++) begin : g_merge
    logic [3:0] src;
    assign src                   = 4'(gi) - first_bytes[3:0];
    assign line2_shl[gi*8 +: 8]  = dc_rd_line[int'(src)*8 +: 8];
    assign merged[gi*8 +: 8]     = (5'(gi) < first_bytes) ? hold_reg[gi*8 +: 8]
                                                          : line2_shl[gi*8 +: 8];
  end

  always_comb begin
    state_next   = state;
    hold_next    = hold_reg;
    ld_data_next = ld_data_reg;
    case (state)
      ST_IDLE: if (ld_req) state_next = ST_ACC1;
      ST_ACC1: begin
        if (dc_rd_valid) begin
          hold_next = line1_rot;
          if (split_reg) begin
            state_next = ST_ACC2;
          end else begin
            state_next   = ST_OUT;
            ld_data_next = line1_rot[C_DATA_W-1:0] & size_mask(size_reg);
          end
        end
      end
      ST_ACC2: begin
        if (dc_rd_valid) begin
          hold_next    = merged;
          state_next   = ST_OUT;
          ld_data_next = merged[C_DATA_W-1:0] & size_mask(size_reg);
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Flush wins over everything: abort and leave the data registers untouched.
    if (flush) begin
      state_next   = ST_IDLE;
      hold_next    = hold_reg;
      ld_data_next = ld_data_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      size_reg    <= SZ_1B;
      offset_reg  <= '0;
      split_reg   <= 1'b0;
      hold_reg    <= '0;
      ld_data_reg <= '0;
    end else begin
      state       <= state_next;
      hold_reg    <= hold_next;
      ld_data_reg <= ld_data_next;
      if (accept) begin
        size_reg   <= size_t'(mem_rd_size);
        offset_reg <= addr_offset;
        split_reg  <= split_in;
      end
    end
  end

  assign ld_ready      = (state == ST_IDLE);
  assign access2       = (state == ST_ACC2);
  assign ld_data_valid = (state == ST_OUT);
  assign ld_data       = ld_data_reg;

endmodule

// File: tb/tb_dc_rd_data_align.sv
// Self-checking bench for dc_rd_data_align: directed and random loads,
// scoreboard of expected results, flush and async-reset scenarios.
module tb_dc_rd_data_align;

  logic         clk = 1'b0;
  logic         rst;
  logic         ld_req;
  logic         ld_ready;
  logic [1:0]   mem_rd_size;
  logic [3:0]   addr_offset;
  logic         dc_rd_valid;
  logic [127:0] dc_rd_line;
  logic         access2;
  logic         flush;
  logic [63:0]  ld_data;
  logic         ld_data_valid;

  int           n_checks = 0;
  int           n_errors = 0;
  int           n_pulses = 0;
  int           n_expected = 0;
  logic [63:0]  sb[$];
  logic [63:0]  last_data = '0;

  dc_rd_data_align dut (
    .clk           (clk),
    .rst           (rst),
    .ld_req        (ld_req),
    .ld_ready      (ld_ready),
    .mem_rd_size   (mem_rd_size),
    .addr_offset   (addr_offset),
    .dc_rd_valid   (dc_rd_valid),
    .dc_rd_line    (dc_rd_line),
    .access2       (access2),
    .flush         (flush),
    .ld_data       (ld_data),
    .ld_data_valid (ld_data_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte i of the result is byte (off+i) of the two lines laid end to end.
  function automatic logic [63:0] ref_load(input logic [1:0] sz, input logic [3:0] off,
                                           input logic [127:0] l1, input logic [127:0] l2);
    logic [255:0] cat;
    logic [63:0]  r;
    int           nb;
    cat = {l2, l1};
    r   = '0;
    nb  = 1 << sz;
    for (int i = 0; i < nb; i++) r[i*8 +: 8] = cat[(int'(off) + i)*8 +: 8];
    return r;
  endfunction

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] ramp_line(input logic [7:0] base);
    logic [127:0] l;
    for (int k = 0; k < 16; k++) l[k*8 +: 8] = base + 8'(k);
    return l;
  endfunction

  always @(negedge clk) begin
    if (!rst && ld_data_valid) begin
      logic [63:0] e;
      n_pulses++;
      chk("sb_occupancy", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_data", ld_data, e);
      end
    end
  end

  task automatic accept_load(input logic [1:0] sz, input logic [3:0] off);
    @(posedge clk); #1;
    chk("ready_idle", 64'(ld_ready), 64'd1);
    ld_req      = 1'b1;
    mem_rd_size = sz;
    addr_offset = off;
    @(posedge clk); #1;
    ld_req      = 1'b0;
    mem_rd_size = 2'($urandom);
    addr_offset = 4'($urandom);
  endtask

  task automatic do_load(input logic [1:0] sz, input logic [3:0] off,
                         input logic [127:0] l1, input logic [127:0] l2,
                         input int d1, input int d2);
    logic [63:0] e;
    bit          split;
    split = (int'(off) + (1 << sz)) > 16;
    e     = ref_load(sz, off, l1, l2);
    sb.push_back(e);
    n_expected++;
    accept_load(sz, off);
    repeat (d1) begin
      @(negedge clk);
      chk("acc1_access2", 64'(access2), 64'd0);
      chk("acc1_ready", 64'(ld_ready), 64'd0);
      @(posedge clk); #1;
    end
    dc_rd_valid = 1'b1;
    dc_rd_line  = l1;
    @(posedge clk); #1;
    dc_rd_valid = 1'b0;
    dc_rd_line  = rand_line();
    if (split) begin
      repeat (d2) begin
        @(negedge clk);
        chk("acc2_access2", 64'(access2), 64'd1);
        chk("acc2_valid", 64'(ld_data_valid), 64'd0);
        @(posedge clk); #1;
      end
      @(negedge clk);
      chk("acc2_access2_b", 64'(access2), 64'd1);
      dc_rd_valid = 1'b1;
      dc_rd_line  = l2;
      @(posedge clk); #1;
      dc_rd_valid = 1'b0;
      dc_rd_line  = rand_line();
    end
    @(negedge clk);
    chk("out_valid", 64'(ld_data_valid), 64'd1);
    chk("out_data", ld_data, e);
    chk("out_access2", 64'(access2), 64'd0);
    chk("out_ready", 64'(ld_ready), 64'd0);
    $display("load size=%0d off=%0d split=%0d data=%h exp=%h", sz, off, split, ld_data, e);
    last_data = e;
  endtask

  initial begin
    logic [127:0] l1, l2;
    rst         = 1'b1;
    ld_req      = 1'b0;
    mem_rd_size = '0;
    addr_offset = '0;
    dc_rd_valid = 1'b0;
    dc_rd_line  = '0;
    flush       = 1'b0;
    #1;
    chk("rst_ready", 64'(ld_ready), 64'd1);
    chk("rst_access2", 64'(access2), 64'd0);
    chk("rst_data", ld_data, 64'd0);
    chk("rst_valid", 64'(ld_data_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed cases from the test plan.
    do_load(2'b10, 4'd4, ramp_line(8'h00), rand_line(), 0, 0);
    chk("nonsplit_4b_value", last_data, 64'h0000_0000_0706_0504);
    do_load(2'b11, 4'd12, ramp_line(8'h00), ramp_line(8'h10), 0, 0);
    chk("split_8b_value", last_data, 64'h1312_1110_0F0E_0D0C);
    l1 = rand_line(); l1[127:120] = 8'hAA;
    l2 = rand_line(); l2[7:0]     = 8'hBB;
    do_load(2'b01, 4'd15, l1, l2, 1, 2);
    chk("split_2b_value", last_data, 64'h0000_0000_0000_BBAA);
    l1 = rand_line();
    do_load(2'b00, 4'd15, l1, rand_line(), 2, 0);
    do_load(2'b11, 4'd8, l1, rand_line(), 0, 0);
    do_load(2'b10, 4'd13, rand_line(), rand_line(), 0, 1);
    do_load(2'b11, 4'd0, rand_line(), rand_line(), 3, 0);

    // Flush in ACC2 together with the second return: no pulse, back to idle.
    accept_load(2'b11, 4'd12);
    dc_rd_valid = 1'b1; dc_rd_line = ramp_line(8'h40);
    @(posedge clk); #1;
    flush = 1'b1; dc_rd_line = ramp_line(8'h80);
    @(posedge clk); #1;
    flush = 1'b0; dc_rd_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", 64'(ld_data_valid), 64'd0);
    chk("flush_ready", 64'(ld_ready), 64'd1);
    chk("flush_access2", 64'(access2), 64'd0);
    chk("flush_data_held", ld_data, last_data);
    $display("flush in ACC2: ready=%0d access2=%0d", ld_ready, access2);

    // Flush with a request in IDLE drops the request.
    @(posedge clk); #1;
    ld_req = 1'b1; flush = 1'b1; mem_rd_size = 2'b11; addr_offset = 4'd9;
    @(posedge clk); #1;
    ld_req = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_req_dropped", 64'(ld_ready), 64'd1);
    $display("flush with ld_req: ready=%0d", ld_ready);

    // Async reset in ACC1 after a stall.
    do_load(2'b10, 4'd2, rand_line(), rand_line(), 0, 0);
    accept_load(2'b01, 4'd3);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_ready", 64'(ld_ready), 64'd1);
    chk("arst_access2", 64'(access2), 64'd0);
    chk("arst_data", ld_data, 64'd0);
    chk("arst_valid", 64'(ld_data_valid), 64'd0);
    $display("async reset mid-load: ready=%0d data=%h", ld_ready, ld_data);
    @(posedge clk); #1 rst = 1'b0;
    do_load(2'b01, 4'd6, rand_line(), rand_line(), 1, 0);

    // Random loads.
    for (int n = 0; n < 24; n++)
      do_load(2'($urandom), 4'($urandom), rand_line(), rand_line(),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    @(posedge clk); @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("pulse_count", 64'(n_pulses), 64'(n_expected));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
